// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               direction counters, one-cycle registered update path and a
//               saturating mispredict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [15:0] mispredict_count
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    localparam logic [1:0]  c_CTR_ALLOC = 2'b10;
    localparam logic [1:0]  c_CTR_MAX   = 2'b11;
    localparam logic [1:0]  c_CTR_MIN   = 2'b00;
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    // Table storage; only the valid bits need a reset.
    logic [ENTRIES-1:0] r_valid;
    logic [TAGW-1:0]    r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    // Pending update captured one cycle before it is written to the table.
    logic               r_pv;
    logic [31:2]        r_ppc;
    logic               r_ptaken;
    logic [31:0]        r_ptarget;

    logic               r_mispredict;
    logic [15:0]        r_mis_cnt;

    logic [IDX-1:0]     w_lk_idx;
    logic               w_lk_hit;
    logic               w_lk_taken;
    logic [IDX-1:0]     w_wr_idx;
    logic               w_wr_hit;
    logic [1:0]         w_ctr_next;
    logic               w_mis;
    logic               w_unused;

    // The low two PC bits never select anything (word-aligned fetch).
    assign w_unused = ^{pc_f[1:0], upd_pc[1:0]};

    // Fetch lookup reads only committed table state, so a write landing on
    // the same edge is never bypassed to the lookup.
    assign w_lk_idx    = pc_f[IDX+1:2];
    assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == pc_f[31:IDX+2]);
    assign w_lk_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign pred_taken  = w_lk_taken;
    assign pred_target = w_lk_taken ? r_target[w_lk_idx] : (pc_f + 32'd4);

    // Write-side hit detection for the pending update.
    assign w_wr_idx = r_ppc[IDX+1:2];
    assign w_wr_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == r_ppc[31:IDX+2]);

    // Next counter value for the pending update: saturating up/down step.
    always_comb begin
        w_ctr_next = r_ctr[w_wr_idx];
        if (r_ptaken) begin
            if (r_ctr[w_wr_idx] != c_CTR_MAX) begin
                w_ctr_next = r_ctr[w_wr_idx] + 2'd1;
            end
        end else begin
            if (r_ctr[w_wr_idx] != c_CTR_MIN) begin
                w_ctr_next = r_ctr[w_wr_idx] - 2'd1;
            end
        end
    end

    assign w_mis = upd_valid &&
                   ((upd_pred_taken != upd_taken) ||
                    (upd_taken && (upd_pred_target != upd_target)));

    // Capture the resolved branch; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv      <= 1'b0;
            r_ppc     <= '0;
            r_ptaken  <= 1'b0;
            r_ptarget <= '0;
        end else begin
            r_pv      <= upd_valid;
            r_ppc     <= upd_pc[31:2];
            r_ptaken  <= upd_taken;
            r_ptarget <= upd_target;
        end
    end

    // Valid bits: set when a taken miss allocates an entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (r_pv && r_ptaken && !w_wr_hit) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Entry payload: counter step on hit, full allocate on taken miss.
    always_ff @(posedge clk) begin
        if (r_pv) begin
            if (w_wr_hit) begin
                r_ctr[w_wr_idx] <= w_ctr_next;
                if (r_ptaken) begin
                    r_target[w_wr_idx] <= r_ptarget;
                end
            end else if (r_ptaken) begin
                r_tag[w_wr_idx]    <= r_ppc[31:IDX+2];
                r_target[w_wr_idx] <= r_ptarget;
                r_ctr[w_wr_idx]    <= c_CTR_ALLOC;
            end
        end
    end

    // Mispredict flag and saturating event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredict <= 1'b0;
            r_mis_cnt    <= '0;
        end else begin
            r_mispredict <= w_mis;
            if (w_mis && (r_mis_cnt != c_CNT_MAX)) begin
                r_mis_cnt <= r_mis_cnt + 16'd1;
            end
        end
    end

    assign mispredict       = r_mispredict;
    assign mispredict_count = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench: directed vector table, hand-written
//               corner sequences and randomized traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int E   = 16;
    localparam int IXB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_f = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        mispredict;
    logic [15:0] mispredict_count;

    int n_pass = 0;
    int n_tot  = 0;

    branch_predictor #(.ENTRIES(E)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_f            (pc_f),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        upt;
        logic [31:0] uptg;
        logic        ept;
        logic [31:0] etg;
        logic        emis;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[20];

    // Reference model state
    bit          m_v   [E];
    logic [31:0] m_tag [E];
    logic [31:0] m_tgt [E];
    int          m_ctr [E];
    bit          p_v;
    logic [31:0] p_pc;
    bit          p_t;
    logic [31:0] p_tg;
    bit          m_mis;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utg, input logic upt,
                         input logic [31:0] uptg);
        @(negedge clk);
        pc_f = pc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
        #1;
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic ept, input logic [31:0] etg);
        pc_f = pc;
        #1;
        chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, ept});
        chk({name, "_target"}, pred_target, etg);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        upd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int ix(input logic [31:0] pc);
        return int'((pc >> 2) % E);
    endfunction

    function automatic logic [31:0] tg(input logic [31:0] pc);
        return pc >> (IXB + 2);
    endfunction

    function automatic logic [31:0] pick_pc();
        logic [31:0] r;
        if ($urandom_range(0, 7) == 0) r = $urandom;
        else r = ($urandom_range(0, 3) << 6) | ($urandom_range(0, E-1) << 2);
        return r;
    endfunction

    // Model: apply last cycle's resolved branch, then capture this cycle's.
    task automatic model_edge();
        int i;
        if (p_v) begin
            i = ix(p_pc);
            if (m_v[i] && m_tag[i] == tg(p_pc)) begin
                if (p_t) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = p_tg;
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (p_t) begin
                m_v[i] = 1; m_tag[i] = tg(p_pc); m_tgt[i] = p_tg; m_ctr[i] = 2;
            end
        end
        p_v = upd_valid; p_pc = upd_pc; p_t = upd_taken; p_tg = upd_target;
        m_mis = upd_valid && ((upd_pred_taken != upd_taken) ||
                              (upd_taken && upd_pred_target != upd_target));
        if (m_mis && m_cnt < 65535) m_cnt++;
    endtask

    initial begin
        logic [31:0] exp_tgt;
        bit          exp_t;
        int          i;

        // Each row: inputs held for one cycle; outputs checked before that
        // cycle's edge (prediction from committed state, flag from last edge).
        //            pc      uv  upc     ut  utg     upt uptg    ept etg     mis cnt
        vecs[0]  = '{32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h104, 0, 16'd0};
        vecs[1]  = '{32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h104, 0, 32'h104, 0, 16'd0};
        vecs[2]  = '{32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h104, 1, 16'd1};
        vecs[3]  = '{32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,   1, 32'h40,  0, 16'd1};
        vecs[4]  = '{32'h100, 1, 32'h100, 1, 32'h40, 1, 32'h44,  1, 32'h40,  0, 16'd1};
        vecs[5]  = '{32'h100, 1, 32'h100, 1, 32'h40, 1, 32'h40,  1, 32'h40,  1, 16'd2};
        vecs[6]  = '{32'h100, 1, 32'h100, 1, 32'h40, 1, 32'h40,  1, 32'h40,  0, 16'd2};
        vecs[7]  = '{32'h100, 1, 32'h100, 0, 32'h0,  1, 32'h40,  1, 32'h40,  0, 16'd2};
        vecs[8]  = '{32'h100, 1, 32'h100, 0, 32'h0,  1, 32'h40,  1, 32'h40,  1, 16'd3};
        vecs[9]  = '{32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,   1, 32'h40,  1, 16'd4};
        vecs[10] = '{32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h104, 0, 16'd4};
        vecs[11] = '{32'h100, 1, 32'h100, 0, 32'h0,  0, 32'h104, 0, 32'h104, 0, 16'd4};
        vecs[12] = '{32'h100, 1, 32'h100, 0, 32'h0,  0, 32'h104, 0, 32'h104, 0, 16'd4};
        vecs[13] = '{32'h100, 1, 32'h100, 0, 32'h0,  0, 32'h104, 0, 32'h104, 0, 16'd4};
        vecs[14] = '{32'h100, 1, 32'h100, 0, 32'h0,  0, 32'h104, 0, 32'h104, 0, 16'd4};
        vecs[15] = '{32'h100, 1, 32'h100, 0, 32'h0,  0, 32'h104, 0, 32'h104, 0, 16'd4};
        vecs[16] = '{32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h104, 0, 16'd4};
        vecs[17] = '{32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h104, 0, 32'h104, 0, 16'd4};
        vecs[18] = '{32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h104, 1, 16'd5};
        // Counter at 01 (not 10) proves the five not-taken updates held it at 00.
        vecs[19] = '{32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h104, 0, 16'd5};

        do_reset();
        for (int v = 0; v < 20; v++) begin
            drive(vecs[v].pc, vecs[v].uv, vecs[v].upc, vecs[v].ut, vecs[v].utg,
                  vecs[v].upt, vecs[v].uptg);
            chk($sformatf("vec%0d_taken", v), {31'd0, pred_taken}, {31'd0, vecs[v].ept});
            chk($sformatf("vec%0d_target", v), pred_target, vecs[v].etg);
            chk($sformatf("vec%0d_mis", v), {31'd0, mispredict}, {31'd0, vecs[v].emis});
            chk($sformatf("vec%0d_cnt", v), {16'd0, mispredict_count}, {16'd0, vecs[v].ecnt});
        end

        // Aliasing: 0x140 shares index 0 with 0x100 and replaces it.
        drive(32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h104);
        drive(32'h100, 1, 32'h140, 1, 32'h80, 0, 32'h144);
        drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        look("alias_pre", 32'h100, 1'b1, 32'h40);
        drive(32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        look("alias_new", 32'h140, 1'b1, 32'h80);
        look("alias_old", 32'h100, 1'b0, 32'h104);

        // Reset with an update pending: it must be discarded.
        drive(32'h200, 1, 32'h200, 1, 32'h300, 0, 32'h204);
        @(negedge clk);
        upd_valid = 1'b0;
        chk("pend_mis_before_rst", {31'd0, mispredict}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_mis", {31'd0, mispredict}, 32'd0);
        chk("rst_async_cnt", {16'd0, mispredict_count}, 32'd0);
        look("rst_async_140", 32'h140, 1'b0, 32'h144);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        look("rst_pend_dropped", 32'h200, 1'b0, 32'h204);
        chk("rst_mis_stays0", {31'd0, mispredict}, 32'd0);
        look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Randomized traffic against the model, from a fresh reset.
        do_reset();
        for (int k = 0; k < E; k++) begin
            m_v[k] = 0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 0;
        end
        p_v = 0; p_pc = '0; p_t = 0; p_tg = '0; m_mis = 0; m_cnt = 0;
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] rpc, rupc, rtg;
            logic        rt;
            rpc  = pick_pc();
            rupc = pick_pc();
            rt   = 1'($urandom_range(0, 1));
            rtg  = $urandom & 32'hFFFF_FFFC;
            drive(rpc, ($urandom_range(0, 3) != 0), rupc, rt, rtg,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? rtg : ($urandom & 32'hFFFF_FFFC));
            i = ix(rpc);
            exp_t   = m_v[i] && (m_tag[i] == tg(rpc)) && (m_ctr[i] >= 2);
            exp_tgt = exp_t ? m_tgt[i] : rpc + 32'd4;
            chk("rnd_taken", {31'd0, pred_taken}, {31'd0, exp_t});
            chk("rnd_target", pred_target, exp_tgt);
            chk("rnd_mis", {31'd0, mispredict}, {31'd0, m_mis});
            chk("rnd_cnt", {16'd0, mispredict_count}, m_cnt);
            @(posedge clk);
            model_edge();
        end

        // Count saturation: 65540 consecutive mispredicted updates.
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b0; upd_pred_taken = 1'b1;
        repeat (65540) @(negedge clk);
        #1;
        chk("sat_cnt", {16'd0, mispredict_count}, 32'h0000_FFFF);
        chk("sat_mis", {31'd0, mispredict}, 32'd1);
        upd_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_mis0", {31'd0, mispredict}, 32'd0);
        chk("idle_cnt_hold", {16'd0, mispredict_count}, 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
